// File: rtl/conv_arb_pkg.sv
// Shared types and default sizing for the converter stream arbiter.
package conv_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ      = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin winner search: first set request at or above ptr, else first below it.
module rr_priority_select #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             found
);

    logic          hi_found;
    logic          lo_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Splitting the ring at ptr avoids a modulo index into req.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (req[k]) begin
                if (32'(ptr) <= k) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IW'(k);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(k);
                end
            end
        end
        found  = hi_found | lo_found;
        winner = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/converter_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding one data_width_converter input.
module converter_stream_arbiter
    import conv_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = DEF_N_REQ,
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int unsigned KW         = DATA_WIDTH / 8,
    localparam int unsigned IW         = $clog2(N_REQ)
) (
    input  logic                        i_clk,
    input  logic                        i_aresetn,
    input  logic [N_REQ-1:0]            i_req_valid,
    output logic [N_REQ-1:0]            o_req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [N_REQ*KW-1:0]         i_req_keep,
    input  logic [N_REQ-1:0]            i_req_last,
    output logic                        o_conv_valid,
    input  logic                        i_conv_ready,
    output logic [DATA_WIDTH-1:0]       o_conv_data,
    output logic [KW-1:0]               o_conv_keep,
    output logic                        o_conv_last,
    output logic [N_REQ-1:0]            o_grant,
    output logic                        o_busy
);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_ptr_nxt;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   owner_nxt;

    logic [IW-1:0]   win_idx;
    logic            win_found;

    logic            own_valid;
    logic            own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic [KW-1:0]   own_keep;
    logic            beat_xfer;

    rr_priority_select #(
        .N_REQ(N_REQ)
    ) u_rr_select (
        .req    (i_req_valid),
        .ptr    (rr_ptr),
        .winner (win_idx),
        .found  (win_found)
    );

    // Slice selection depends only on the registered owner.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        own_keep  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (owner == IW'(k)) begin
                own_valid = i_req_valid[k];
                own_last  = i_req_last[k];
                own_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
                own_keep  = i_req_keep[k*KW +: KW];
            end
        end
    end

    assign o_conv_data = own_data;
    assign o_conv_keep = own_keep;
    assign o_conv_last = own_last;

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        o_conv_valid = 1'b0;
        o_req_ready  = '0;
        o_grant      = '0;
        o_busy       = 1'b0;
        beat_xfer    = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    owner_nxt = win_idx;
                    state_nxt = LOCKED;
                end
            end

            LOCKED: begin
                o_busy       = 1'b1;
                o_conv_valid = own_valid;
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    o_grant[k]     = (owner == IW'(k));
                    o_req_ready[k] = (owner == IW'(k)) & i_conv_ready;
                end
                beat_xfer = own_valid & i_conv_ready;
                if (beat_xfer && own_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_converter_stream_arbiter.sv
// Cycle-vector bench for converter_stream_arbiter with a transferred-beat scoreboard.
module tb_converter_stream_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = DW / 8;

    logic              clk = 1'b0;
    logic              i_aresetn;
    logic [N-1:0]      i_req_valid;
    logic [N-1:0]      o_req_ready;
    logic [N*DW-1:0]   i_req_data;
    logic [N*KW-1:0]   i_req_keep;
    logic [N-1:0]      i_req_last;
    logic              o_conv_valid;
    logic              i_conv_ready;
    logic [DW-1:0]     o_conv_data;
    logic [KW-1:0]     o_conv_keep;
    logic              o_conv_last;
    logic [N-1:0]      o_grant;
    logic              o_busy;

    converter_stream_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk        (clk),
        .i_aresetn    (i_aresetn),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_data   (i_req_data),
        .i_req_keep   (i_req_keep),
        .i_req_last   (i_req_last),
        .o_conv_valid (o_conv_valid),
        .i_conv_ready (i_conv_ready),
        .o_conv_data  (o_conv_data),
        .o_conv_keep  (o_conv_keep),
        .o_conv_last  (o_conv_last),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rstn;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         ready;
        int           src;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [N-1:0] eg;
        logic         eb;
        logic         ecv;
        logic [N-1:0] err;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [N-1:0]  grant;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;

    function automatic vec_t mk(string name, logic rstn, logic [N-1:0] valid, logic [N-1:0] last,
                                logic ready, int src, logic [DW-1:0] data, logic [KW-1:0] keep,
                                logic [N-1:0] eg, logic eb, logic ecv, logic [N-1:0] err);
        vec_t v;
        v.name = name; v.rstn = rstn; v.valid = valid; v.last = last; v.ready = ready;
        v.src = src; v.data = data; v.keep = keep;
        v.eg = eg; v.eb = eb; v.ecv = ecv; v.err = err;
        return v;
    endfunction

    // Source slice carries the row's data/keep exactly; other slices are perturbed.
    function automatic logic [DW-1:0] slice_data(vec_t v, int k);
        if (k == v.src) return v.data;
        return v.data ^ (32'(k + 1) << 28);
    endfunction

    function automatic logic [KW-1:0] slice_keep(vec_t v, int k);
        if (k == v.src) return v.keep;
        return v.keep ^ KW'(k + 1);
    endfunction

    function automatic int oh2idx(logic [N-1:0] g);
        int r = 0;
        for (int k = 0; k < N; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic apply(vec_t v);
        beat_t b;
        int    g;
        i_aresetn    = v.rstn;
        i_req_valid  = v.valid;
        i_req_last   = v.last;
        i_conv_ready = v.ready;
        for (int k = 0; k < N; k++) begin
            i_req_data[k*DW +: DW] = slice_data(v, k);
            i_req_keep[k*KW +: KW] = slice_keep(v, k);
        end
        if (v.ecv && v.ready) begin
            g       = oh2idx(v.eg);
            b.data  = slice_data(v, g);
            b.keep  = slice_keep(v, g);
            b.last  = v.last[g];
            b.grant = v.eg;
            sb.push_back(b);
        end
    endtask

    task automatic chk(string name, int row, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (o_conv_valid === 1'b1 && i_conv_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: data=%h keep=%b last=%b grant=%b with empty scoreboard",
                         o_conv_data, o_conv_keep, o_conv_last, o_grant);
            end else begin
                e = sb.pop_front();
                if ({o_conv_data, o_conv_keep, o_conv_last, o_grant} !== e) begin
                    errors++;
                    $display("FAIL beat: got data=%h keep=%b last=%b grant=%b expected data=%h keep=%b last=%b grant=%b",
                             o_conv_data, o_conv_keep, o_conv_last, o_grant,
                             e.data, e.keep, e.last, e.grant);
                end
            end
        end
    end

    initial begin
        i_aresetn    = 1'b0;
        i_req_valid  = '0;
        i_req_last   = '0;
        i_req_data   = '0;
        i_req_keep   = '0;
        i_conv_ready = 1'b0;

        // reset state
        tbl.push_back(mk("rst",    0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("rst",    0, 4'b1111, 4'b0000, 1, 0, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        // single requester, 3 beats
        tbl.push_back(mk("single", 1, 4'b0001, 4'b0000, 1, 0, 32'h11111111, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("single", 1, 4'b0001, 4'b0000, 1, 0, 32'h11111111, 4'hF, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk("single", 1, 4'b0001, 4'b0000, 1, 0, 32'h22222222, 4'hF, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk("single", 1, 4'b0001, 4'b0001, 1, 0, 32'h33333333, 4'hF, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk("single", 1, 4'b0000, 4'b0000, 1, 0, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        // fairness with 1-beat packets from a fresh reset
        tbl.push_back(mk("fair",   0, 4'b0000, 4'b0000, 1, 0, 32'hC0DE0000, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0000, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0000, 4'hF, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0001, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0001, 4'hF, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0002, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0002, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0003, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0003, 4'hF, 4'b1000, 1, 1, 4'b1000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0004, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("fair",   1, 4'b1111, 4'b1111, 1, 0, 32'hC0DE0004, 4'hF, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk("fair",   1, 4'b0000, 4'b0000, 1, 0, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        // backpressure on a 4-beat req2 packet
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0000, 1, 2, 32'h20000001, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0000, 1, 2, 32'h20000001, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0000, 0, 2, 32'h20000002, 4'hF, 4'b0100, 1, 1, 4'b0000));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0000, 1, 2, 32'h20000002, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0000, 0, 2, 32'h20000003, 4'hF, 4'b0100, 1, 1, 4'b0000));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0000, 1, 2, 32'h20000003, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0100, 0, 2, 32'h20000004, 4'hF, 4'b0100, 1, 1, 4'b0000));
        tbl.push_back(mk("bp",     1, 4'b0100, 4'b0100, 1, 2, 32'h20000004, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("bp",     1, 4'b0000, 4'b0000, 1, 2, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        // req1 drops valid mid-packet while req3 waits
        tbl.push_back(mk("gap",    1, 4'b0010, 4'b0000, 1, 1, 32'h1000000A, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("gap",    1, 4'b1010, 4'b0000, 1, 1, 32'h1000000A, 4'hF, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk("gap",    1, 4'b1000, 4'b0000, 1, 1, 32'h1000000B, 4'hF, 4'b0010, 1, 0, 4'b0010));
        tbl.push_back(mk("gap",    1, 4'b1000, 4'b0000, 1, 1, 32'h1000000B, 4'hF, 4'b0010, 1, 0, 4'b0010));
        tbl.push_back(mk("gap",    1, 4'b1010, 4'b0010, 1, 1, 32'h1000000B, 4'hF, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk("gap",    1, 4'b1000, 4'b1000, 1, 3, 32'h3000000C, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("gap",    1, 4'b1000, 4'b1000, 1, 3, 32'h3000000C, 4'hF, 4'b1000, 1, 1, 4'b1000));
        tbl.push_back(mk("gap",    1, 4'b0000, 4'b0000, 1, 3, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        // move rr_ptr off zero, then reset during beat 2 of a req2 packet
        tbl.push_back(mk("mrst",   1, 4'b0010, 4'b0010, 1, 1, 32'h1111AAAA, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("mrst",   1, 4'b0010, 4'b0010, 1, 1, 32'h1111AAAA, 4'hF, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk("mrst",   1, 4'b0100, 4'b0000, 1, 2, 32'h2222BBB1, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("mrst",   1, 4'b0100, 4'b0000, 1, 2, 32'h2222BBB1, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("mrst",   0, 4'b0100, 4'b0000, 1, 2, 32'h2222BBB2, 4'hF, 4'b0100, 1, 1, 4'b0100));
        tbl.push_back(mk("mrst",   0, 4'b0100, 4'b0000, 1, 2, 32'h2222BBB3, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("mrst",   1, 4'b0101, 4'b0101, 1, 0, 32'h0000D00D, 4'hF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("mrst",   1, 4'b0101, 4'b0101, 1, 0, 32'h0000D00D, 4'hF, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk("mrst",   1, 4'b0000, 4'b0000, 1, 0, 32'h0,        4'hF, 4'b0000, 0, 0, 4'b0000));
        // partial keep passes through untouched
        tbl.push_back(mk("keep",   1, 4'b0010, 4'b0010, 1, 1, 32'hABCDEFAB, 4'b0111, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk("keep",   1, 4'b0010, 4'b0010, 1, 1, 32'hABCDEFAB, 4'b0111, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk("keep",   1, 4'b0000, 4'b0000, 1, 1, 32'h0,        4'hF,    4'b0000, 0, 0, 4'b0000));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk({tbl[i].name, "_grant"}, i, o_grant, tbl[i].eg);
            chk({tbl[i].name, "_busy"},  i, {3'b000, o_busy}, {3'b000, tbl[i].eb});
            chk({tbl[i].name, "_cvalid"}, i, {3'b000, o_conv_valid}, {3'b000, tbl[i].ecv});
            chk({tbl[i].name, "_ready"}, i, o_req_ready, tbl[i].err);
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d beats outstanding expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/converter_stream_arbiter.md
CONVERTER_STREAM_ARBITER -- requirements
Module: converter_stream_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requester streams, range 2..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: requester and converter input width in bits, a multiple of 8.

Ports (all widths follow from the parameters; KW = DATA_WIDTH/8):
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_req_valid, input, N_REQ bits: per-requester valid.
REQ-006 The block SHALL have port o_req_ready, output, N_REQ bits: per-requester ready.
REQ-007 The block SHALL have port i_req_data, input, N_REQ*DATA_WIDTH bits: packed requester data, requester k at slice k.
REQ-008 The block SHALL have port i_req_keep, input, N_REQ*KW bits: packed requester byte-enables.
REQ-009 The block SHALL have port i_req_last, input, N_REQ bits: per-requester end-of-packet flag.
REQ-010 The block SHALL have port o_conv_valid, output, 1 bit: valid toward the data_width_converter input.
REQ-011 The block SHALL have port i_conv_ready, input, 1 bit: ready from the converter (its o_input_ready).
REQ-012 The block SHALL have port o_conv_data, output, DATA_WIDTH bits: converter input data.
REQ-013 The block SHALL have port o_conv_keep, output, KW bits: converter input keep.
REQ-014 The block SHALL have port o_conv_last, output, 1 bit: end of packet toward the converter.
REQ-015 The block SHALL have port o_grant, output, N_REQ bits: one-hot current owner, all zero when idle.
REQ-016 The block SHALL have port o_busy, output, 1 bit: high while in LOCKED.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and LOCKED.
REQ-018 In IDLE with any i_req_valid bit set, the block SHALL register a winner chosen round-robin, searching from index rr_ptr upward with wrap-around, and SHALL enter LOCKED on the next edge (request-to-o_conv_valid latency of 1 cycle).
REQ-019 In IDLE with no i_req_valid bit set, the block SHALL remain in IDLE with o_grant=0.
REQ-020 In IDLE, o_conv_valid and all o_req_ready bits SHALL be 0.
REQ-021 In LOCKED with owner g: o_conv_valid=i_req_valid[g]; o_conv_data, o_conv_keep and o_conv_last SHALL be slice g of the inputs; o_req_ready[g]=i_conv_ready; all other o_req_ready bits=0.
REQ-022 A beat SHALL be counted as transferred only when o_conv_valid=1 and i_conv_ready=1 in the same cycle.
REQ-023 On a transferred beat with i_req_last[g]=1, the block SHALL return to IDLE and set rr_ptr=(g+1) mod N_REQ, giving one idle bubble cycle between packets.
REQ-024 The owner SHALL be held for the whole packet; deasserting i_req_valid[g] mid-packet SHALL NOT release the grant.
REQ-025 A new request arriving during LOCKED, or in the same cycle as the last beat, SHALL be arbitrated only in the following IDLE cycle.
REQ-026 o_conv_data and o_conv_keep SHALL be passed unmodified; keep is never altered.
REQ-027 The output mux SHALL be combinational from the registered owner index, with no combinational path from i_req_valid to o_req_ready.

Reset
REQ-028 While i_aresetn=0 at a rising edge, the block SHALL set state=IDLE, rr_ptr=0 and owner=0, forcing o_grant=0, o_busy=0, o_conv_valid=0 and o_req_ready=0.
REQ-029 A reset asserted mid-packet SHALL abandon the packet without emitting a terminating o_conv_last; the converter is reset by the same i_aresetn.
REQ-030 In the first cycle after reset release, the block SHALL be in IDLE and arbitrate normally.

Structure
REQ-031 Package conv_arb_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the default N_REQ/DATA_WIDTH constants.
REQ-032 The round-robin winner search SHALL be a sub-module rr_priority_select (inputs req and ptr; outputs winner index and found flag), purely combinational.
REQ-033 State, rr_ptr and owner SHALL be the only registers; the top level SHALL instantiate no converter.

Verification
REQ-034 Single requester: req0 sends 3 beats 0x11111111, 0x22222222, 0x33333333 (keep 0xF, last on beat 3) with i_conv_ready=1 -> o_conv_valid high 1 cycle after the request; same 3 beats in order; o_conv_last on beat 3; o_grant=0001 then 0000.
REQ-035 Fairness: all 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0, one IDLE cycle between grants.
REQ-036 Backpressure: i_conv_ready toggles 1,0,1,0 during a 4-beat req2 packet -> each beat transferred exactly once; o_req_ready[2] mirrors i_conv_ready; other ready bits stay 0.
REQ-037 Valid gap: req1 drops valid for 2 cycles mid-packet while req3 is requesting -> grant stays 0010 until req1's last beat; then req3 is granted.
REQ-038 Reset mid-packet: i_aresetn=0 on beat 2 of 4 -> all outputs 0 on the next cycle; after release, req0 wins first (rr_ptr=0).
REQ-039 Keep passthrough: req1 sends data 0xABCDEFAB with keep 0111 -> o_conv_data=0xABCDEFAB and o_conv_keep=0111 exactly.
